int_div_wb_collector: RTL and testbench
=======================================

Name: int_div_wb_collector

Overview:
- Receiver/consumer end of the integer mult/div pipeline output interface.
- Captures each completed vector result with its destination-register tag and lane mask, and buffers it in a small FIFO.
- Presents buffered results to the register-file writeback port with a valid/ready handshake.
- Drives `stall` back into the pipeline so no result is lost when writeback is blocked.

Parameters:
- VEC_WIDTH, 8, number of lanes per vector (matches `VEC_WIDTH).
- SCALAR_W, 32, bits per lane.
- TAG_W, 5, destination register index width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- STALL_MARGIN, 1, free entries reserved to absorb results already in flight when stall rises.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  pipeline result valid this cycle.
- in_data  in  VEC_WIDTH*SCALAR_W  result vector (`out` of the pipeline).
- in_tag  in  TAG_W  destination register.
- in_mask  in  VEC_WIDTH  per-lane write enable.
- stall  out  1  back-pressure to the pipeline.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  register file accepts the head entry.
- wb_data  out  VEC_WIDTH*SCALAR_W  head entry data.
- wb_tag  out  TAG_W  head entry tag.
- wb_mask  out  VEC_WIDTH  head entry mask.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow_err  out  1  sticky: a result was dropped.

Behaviour:
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, wb_valid=0, stall=0, overflow_err=0. wb_data/wb_tag/wb_mask read as 0 while empty.
- Push: in_valid=1 and (count<DEPTH or pop this cycle). Entry {data, tag, mask} is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: wb_valid=1 and wb_ready=1. rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: count unchanged; accepted even when count==DEPTH.
- Push and pop in the same cycle while count==0: the entry is written and wb_valid rises next cycle. No bypass; see Optional Feature.
- Latency: minimum 1 cycle from in_valid to wb_valid.
- wb_valid = (count != 0). Outputs are driven from the head entry, combinationally from storage.
- Once wb_valid=1, wb_data/wb_tag/wb_mask stay stable until the pop.
- stall is registered: stall_next = (count_next ≥ DEPTH−STALL_MARGIN). It deasserts the cycle after count_next drops below the threshold.
- The pipeline stops producing the cycle after stall; STALL_MARGIN covers the one in-flight result.
- Overflow: in_valid=1, count==DEPTH and no pop.
  - The result is dropped.
  - overflow_err is set and held until reset.
  - count and pointers are unchanged.
- in_mask==0 is still buffered; the consumer decides what to do with it.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy comes from the separate count register, not pointer compare.
- Reset mid-operation discards all entries immediately. wb_valid falls asynchronously.

Optional Feature:
- Macro WBC_BYPASS_EN.
- When defined: if count==0, in_valid=1 and wb_ready=1, the input passes combinationally to wb_* with wb_valid=1 in the same cycle. Nothing is written and count stays 0.
  - If wb_ready=0 in that case, the entry is written normally.
- When undefined: minimum latency is 1 cycle as above, and there is no combinational path from in_* to wb_*.

Decomposition:
- Shared package (wbc_pkg) holds:
  - WbEntry_t struct {Vector_t data; logic [TAG_W-1:0] tag; logic [VEC_WIDTH-1:0] mask}.
  - Tag width constant, shared with the decode/scoreboard.
- Sub-module wbc_entry_ram: DEPTH×WbEntry_t register array, one write port, one async read port, no reset on data.
- Top level holds pointers, count, stall and overflow logic.

Test Plan:
- Reset, then 3 pushes with tags 1,2,3, data lane0=0x11/0x22/0x33, wb_ready=1 → wb_tag 1,2,3 in order, one per cycle starting 1 cycle after the first push; count returns to 0.
- wb_ready=0, pushes until count reaches 3 (DEPTH=4, STALL_MARGIN=1) → stall=1 the following cycle; one more push gives count=4; overflow_err stays 0.
- Full (count=4), wb_ready=0, in_valid=1 → count stays 4, overflow_err=1 and sticky; entry contents unchanged on pop.
- Full with in_valid=1 and wb_ready=1 in the same cycle → count stays 4, new entry lands at the tail, head advances, overflow_err=0.
- Push 8 entries interleaved with pops (wrap twice) → order and data preserved, tags 0..7 observed.
- rst asserted with count=2 → wb_valid=0 and count=0 immediately. With WBC_BYPASS_EN, an empty FIFO with in_valid=1 and wb_ready=1 gives wb_valid=1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/wbc_pkg.sv
// Shared types for the mult/div writeback collector.
// Entry layout and the tag width are reused by decode/scoreboard.
package wbc_pkg;
  localparam int VEC_WIDTH = 8;
  localparam int SCALAR_W  = 32;
  localparam int TAG_W     = 5;

  typedef logic [VEC_WIDTH*SCALAR_W-1:0] Vector_t;

  typedef struct packed {
    Vector_t                data;
    logic [TAG_W-1:0]       tag;
    logic [VEC_WIDTH-1:0]   mask;
  } WbEntry_t;
endpackage

// File: rtl/wbc_entry_ram.sv
// Result storage: DEPTH entries, one write port, async read.
// Data is not reset; occupancy is tracked by the owner.
module wbc_entry_ram
  import wbc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  WbEntry_t      wdata_i,
  input  logic [PW-1:0] raddr_i,
  output WbEntry_t      rdata_o
);

  WbEntry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/int_div_wb_collector.sv
// Writeback FIFO between the mult/div pipeline and the register file.
// Optional same-cycle bypass when empty: define WBC_BYPASS_EN.
module int_div_wb_collector
  import wbc_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [VEC_WIDTH*SCALAR_W-1:0] in_data,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [VEC_WIDTH-1:0]          in_mask,
  output logic                          stall,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [VEC_WIDTH*SCALAR_W-1:0] wb_data,
  output logic [TAG_W-1:0]              wb_tag,
  output logic [VEC_WIDTH-1:0]          wb_mask,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_MARGIN);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, ovf_q;

  logic     empty, full, byp;
  logic     push, pop, drop;
  WbEntry_t wr_ent, head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef WBC_BYPASS_EN
  assign byp = empty & in_valid & wb_ready;
`else
  assign byp = 1'b0;
`endif

  assign pop  = ~empty & wb_ready;
  assign push = in_valid & (~full | pop) & ~byp;
  assign drop = in_valid & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push & ~pop) begin
      count_d = count_q + CW'(1);
    end else if (pop & ~push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      stall_q <= (count_d >= STALL_TH);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign wr_ent.data = in_data;
  assign wr_ent.tag  = in_tag;
  assign wr_ent.mask = in_mask;

  wbc_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_ent),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Empty FIFO reads as zero rather than stale storage.
  always_comb begin
    wb_valid = ~empty;
    wb_data  = empty ? '0 : head.data;
    wb_tag   = empty ? '0 : head.tag;
    wb_mask  = empty ? '0 : head.mask;
    if (byp) begin
      wb_valid = 1'b1;
      wb_data  = in_data;
      wb_tag   = in_tag;
      wb_mask  = in_mask;
    end
  end

  assign stall        = stall_q;
  assign count        = count_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_int_div_wb_collector.sv
// Directed bench for int_div_wb_collector (DEPTH=4, STALL_MARGIN=1).
// Default build; WBC_BYPASS_EN adds a same-cycle bypass step.
module tb_int_div_wb_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [255:0] in_data;
  logic [4:0]   in_tag;
  logic [7:0]   in_mask;
  logic         stall;
  logic         wb_valid;
  logic         wb_ready;
  logic [255:0] wb_data;
  logic [4:0]   wb_tag;
  logic [7:0]   wb_mask;
  logic [2:0]   count;
  logic         overflow_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_div_wb_collector #(.DEPTH(4), .STALL_MARGIN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_tag       (in_tag),
    .in_mask      (in_mask),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_tag       (wb_tag),
    .wb_mask      (wb_mask),
    .count        (count),
    .overflow_err (overflow_err)
  );

  function automatic logic [255:0] mk(input logic [31:0] v);
    return {v | 32'hA500_0000, 192'd0, v};
  endfunction

  task automatic chk(input string nm, input logic [255:0] o,
                     input logic [255:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] t,
                      input logic [31:0] d, input logic [7:0] m,
                      input logic r);
    in_valid = v;
    in_tag   = t;
    in_data  = mk(d);
    in_mask  = m;
    wb_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int q[$];
  int n;
  logic rdy, vld, pp, ps;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_tag = '0;
    in_data = '0;
    in_mask = '0;
    wb_ready = 1'b0;
    #3;
    chk("rst_count", 256'(count), 256'd0);
    chk("rst_valid", 256'(wb_valid), 256'd0);
    chk("rst_stall", 256'(stall), 256'd0);
    chk("rst_ovf", 256'(overflow_err), 256'd0);
    chk("rst_tag", 256'(wb_tag), 256'd0);
    chk("rst_data", wb_data, 256'd0);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // in-order streaming with ready high
    step(1, 5'd1, 32'h11, 8'hFF, 1);
    chk("s1_valid", 256'(wb_valid), 256'd1);
    chk("s1_tag", 256'(wb_tag), 256'd1);
    chk("s1_data", wb_data, mk(32'h11));
    chk("s1_count", 256'(count), 256'd1);
    step(1, 5'd2, 32'h22, 8'hF0, 1);
    chk("s2_tag", 256'(wb_tag), 256'd2);
    chk("s2_data", wb_data, mk(32'h22));
    chk("s2_mask", 256'(wb_mask), 256'hF0);
    chk("s2_count", 256'(count), 256'd1);
    step(1, 5'd3, 32'h33, 8'h00, 1);
    chk("s3_tag", 256'(wb_tag), 256'd3);
    chk("s3_mask0", 256'(wb_mask), 256'h00);
    chk("s3_valid", 256'(wb_valid), 256'd1);
    step(0, 5'd0, 32'h0, 8'h00, 1);
    chk("s4_count", 256'(count), 256'd0);
    chk("s4_valid", 256'(wb_valid), 256'd0);
    chk("s4_tag0", 256'(wb_tag), 256'd0);

    // fill with ready low, watch stall
    step(1, 5'd4, 32'd4, 8'h01, 0);
    chk("f1_count", 256'(count), 256'd1);
    step(1, 5'd5, 32'd5, 8'h02, 0);
    chk("f2_stall", 256'(stall), 256'd0);
    step(1, 5'd6, 32'd6, 8'h04, 0);
    chk("f3_count", 256'(count), 256'd3);
    chk("f3_stall", 256'(stall), 256'd1);
    step(1, 5'd7, 32'd7, 8'h08, 0);
    chk("f4_count", 256'(count), 256'd4);
    chk("f4_stall", 256'(stall), 256'd1);
    chk("f4_ovf", 256'(overflow_err), 256'd0);
    chk("f4_head", 256'(wb_tag), 256'd4);

    // full, push and pop together
    step(1, 5'd9, 32'd9, 8'h10, 1);
    chk("fp_count", 256'(count), 256'd4);
    chk("fp_head", 256'(wb_tag), 256'd5);
    chk("fp_ovf", 256'(overflow_err), 256'd0);

    // full, no pop: dropped
    step(1, 5'd10, 32'd10, 8'h20, 0);
    chk("ov_count", 256'(count), 256'd4);
    chk("ov_flag", 256'(overflow_err), 256'd1);
    chk("ov_head", 256'(wb_tag), 256'd5);
    step(0, 5'd0, 32'd0, 8'h00, 0);
    chk("ov_sticky", 256'(overflow_err), 256'd1);

    // drain: 5,6,7,9 remain
    step(0, 5'd0, 32'd0, 8'h00, 1);
    chk("d1_head", 256'(wb_tag), 256'd6);
    chk("d1_data", wb_data, mk(32'd6));
    chk("d1_stall", 256'(stall), 256'd1);
    step(0, 5'd0, 32'd0, 8'h00, 1);
    chk("d2_head", 256'(wb_tag), 256'd7);
    chk("d2_stall", 256'(stall), 256'd0);
    step(0, 5'd0, 32'd0, 8'h00, 1);
    chk("d3_head", 256'(wb_tag), 256'd9);
    chk("d3_data", wb_data, mk(32'd9));
    chk("d3_mask", 256'(wb_mask), 256'h10);
    step(0, 5'd0, 32'd0, 8'h00, 1);
    chk("d4_count", 256'(count), 256'd0);
    chk("d4_ovf", 256'(overflow_err), 256'd1);

    do_reset();
    chk("rr_ovf", 256'(overflow_err), 256'd0);

    // wrap twice with irregular pops, tags 0..7
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (n == 8 && q.size() == 0) break;
      vld = (n < 8);
      rdy = (i % 3 != 0);
      pp  = (q.size() != 0) && rdy;
      ps  = vld && (q.size() < 4 || pp);
      step(vld, 5'(n), 32'(n), 8'(n), rdy);
      if (pp) void'(q.pop_front());
      if (ps) begin
        q.push_back(n);
        n++;
      end
      chk("w_count", 256'(count), 256'(q.size()));
      if (q.size() != 0) begin
        chk("w_tag", 256'(wb_tag), 256'(q[0]));
        chk("w_data", wb_data, mk(32'(q[0])));
      end
    end
    chk("w_empty", 256'(wb_valid), 256'd0);

    // async reset with two entries held
    step(1, 5'd20, 32'd20, 8'hAA, 0);
    step(1, 5'd21, 32'd21, 8'h55, 0);
    chk("ar_pre", 256'(count), 256'd2);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", 256'(wb_valid), 256'd0);
    chk("ar_count", 256'(count), 256'd0);
    chk("ar_tag", 256'(wb_tag), 256'd0);
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;

`ifdef WBC_BYPASS_EN
    in_valid = 1'b1;
    in_tag   = 5'd21;
    in_data  = mk(32'd21);
    in_mask  = 8'h3C;
    wb_ready = 1'b1;
    #1;
    chk("bp_valid", 256'(wb_valid), 256'd1);
    chk("bp_tag", 256'(wb_tag), 256'd21);
    chk("bp_data", wb_data, mk(32'd21));
    @(posedge clk);
    #1;
    chk("bp_count", 256'(count), 256'd0);
    in_valid = 1'b0;
    #1;
    chk("bp_idle", 256'(wb_valid), 256'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
